stack_unit: RTL and testbench

//  Hardware LIFO operand stack for the multicycle stack-machine CPU.

---
 rtl/stack_unit.sv | 173 +++++++++++++++++
 tb/tb_stack_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//   Hardware LIFO operand stack for the multicycle stack-machine CPU.
//   Accepts the controller's push/pop strobes, supplies the top-of-stack value,
//   registered pop results and the ZERO flag used by JZ. Overflow and underflow
//   are sticky and move the stack into an error state. In that state the stack
//   is frozen until clr_err is asserted.
//
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous, active-high reset
//   push       in   1         push request
//   pop        in   1         pop request
//   push_data  in   DATA_W    data written on push
//   clr_err    in   1         clears error flags and leaves the error state
//   pop_data   out  DATA_W    value removed by the last accepted pop
//   pop_valid  out  1         pulse: pop_data updated by the previous edge
//   tos_data   out  DATA_W    current top of stack, 0 when empty
//   tos_zero   out  1         top of stack is zero and stack is not empty
//   count      out  ADDR_W+1  number of valid entries, 0..DEPTH
//   empty      out  1         count == 0
//   full       out  1         count == DEPTH
//   overflow   out  1         sticky: push attempted while full
//   underflow  out  1         sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              clr_err,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] tos_data,
    output logic              tos_zero,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int             DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ACTIVE,
        S_FULL,
        S_ERR
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W:0]     sp;        // next free slot; doubles as the entry count
    logic [ADDR_W:0]     sp_next;
    logic [ADDR_W-1:0]   top_idx;
    logic                do_push;
    logic                do_pop;
    logic                do_swap;   // push+pop on a non-empty stack: replace top
    logic                set_ovf;
    logic                set_udf;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign count   = sp;
    assign empty   = (sp == '0);
    assign full    = (sp == FULL_COUNT);
    // Wraps to DEPTH-1 when sp == DEPTH, which is exactly the top slot.
    assign top_idx = sp[ADDR_W-1:0] - ADDR_W'(1);

    assign tos_data = empty ? '0 : mem[top_idx];
    assign tos_zero = !empty && (tos_data == '0);

    function automatic state_t state_for(input logic [ADDR_W:0] c);
        if (c == '0)
            return S_EMPTY;
        else if (c == FULL_COUNT)
            return S_FULL;
        else
            return S_ACTIVE;
    endfunction

    // NOTE: every signal gets a default before any branch so this block can
    // never infer a latch, whatever combination of requests arrives.
    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_swap    = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        sp_next    = sp;
        next_state = state;

        if (clr_err) begin
            // Recovery edge: no operation, state re-derived from the depth.
            next_state = state_for(sp);
        end else if (state != S_ERR) begin
            case ({push, pop})
                2'b10: begin
                    if (full) set_ovf = 1'b1;
                    else      do_push = 1'b1;
                end
                2'b01: begin
                    if (empty) set_udf = 1'b1;
                    else       do_pop  = 1'b1;
                end
                2'b11: begin
                    // On an empty stack the push still lands; only the pop fails.
                    if (empty) begin
                        do_push = 1'b1;
                        set_udf = 1'b1;
                    end else begin
                        do_swap = 1'b1;
                    end
                end
                default: ;
            endcase

            if (do_push)
                sp_next = sp + CNT_ONE;
            else if (do_pop)
                sp_next = sp - CNT_ONE;

            next_state = (set_ovf || set_udf) ? S_ERR : state_for(sp_next);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_EMPTY;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            pop_valid <= do_pop || do_swap;
            if (do_pop || do_swap)
                pop_data <= mem[top_idx];
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (set_ovf) overflow  <= 1'b1;
                if (set_udf) underflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only ever read
    // below sp, and sp is reset, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[sp[ADDR_W-1:0]] <= push_data;
        else if (do_swap)
            mem[top_idx] <= push_data;
    end

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
//   Self-checking bench for stack_unit. A table of single-cycle vectors holds
//   the stimulus and the expected state after each edge; expected pop results
//   go into a scoreboard queue when the request is driven and are compared
//   when pop_valid shows up. Fill-to-full, overflow recovery and mid-cycle
//   reset are written out by hand.
// -----------------------------------------------------------------------------
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] push_data;
    logic       clr_err;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [7:0] tos_data;
    logic       tos_zero;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] din;
        logic       pv;     // a pop result is expected after this edge
        logic [7:0] pd;     // expected pop_data when pv is set
        logic [4:0] cnt;
        logic [7:0] tos;
        logic       ovf;
        logic       udf;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    stack_unit #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .tos_data  (tos_data),
        .tos_zero  (tos_zero),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests, let one rising edge pass, then settle the
    // scoreboard: pop_valid must be high exactly when a result was queued.
    task automatic apply(input logic p_push, input logic p_pop, input logic p_clr,
                         input logic [7:0] p_din);
        logic [7:0] exp_pd;
        logic       want;
        push      = p_push;
        pop       = p_pop;
        clr_err   = p_clr;
        push_data = p_din;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        want    = (exp_q.size() != 0);
        check("pop_valid", 32'(pop_valid), 32'(want));
        if (want) begin
            exp_pd = exp_q.pop_front();
            if (pop_valid)
                check("pop_data", 32'(pop_data), 32'(exp_pd));
        end
    endtask

    task automatic check_state(input string tag, input logic [4:0] c, input logic [7:0] t,
                               input logic ovf, input logic udf);
        check({tag, ".count"},     32'(count),     32'(c));
        check({tag, ".tos_data"},  32'(tos_data),  32'(t));
        check({tag, ".tos_zero"},  32'(tos_zero),  32'((t == 8'h00) && (c != 5'd0)));
        check({tag, ".empty"},     32'(empty),     32'(c == 5'd0));
        check({tag, ".full"},      32'(full),      32'(c == 5'd16));
        check({tag, ".overflow"},  32'(overflow),  32'(ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(udf));
    endtask

    initial begin
        //          push pop clr din    pv  pd     cnt  tos    ovf udf
        // basic push / pop ordering
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 5'd1, 8'h11, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 8'h00, 5'd2, 8'h22, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 8'h00, 5'd3, 8'h33, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 5'd2, 8'h22, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 5'd1, 8'h11, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 5'd0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 8'h00, 1'b0, 1'b0};
        // push+pop replaces the top; zero on top raises tos_zero
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 8'h00, 5'd1, 8'h05, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 5'd1, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 5'd0, 8'h00, 1'b0, 1'b0};
        // pop on empty: underflow, frozen until clr_err; clr_err drops the push
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 5'd0, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 5'd0, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h66, 1'b0, 8'h00, 5'd1, 8'h66, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h66, 5'd0, 8'h00, 1'b0, 1'b0};
        // push+pop on empty: push lands, pop rejected with underflow
        vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 8'h00, 5'd1, 8'h99, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 5'd1, 8'h99, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 5'd1, 8'h99, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 5'd0, 8'h00, 1'b0, 1'b0};

        rst       = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clr_err   = 1'b0;
        push_data = 8'h00;
        #12;
        rst = 1'b0;
        check("reset.pop_valid", 32'(pop_valid), 32'(0));
        check("reset.pop_data",  32'(pop_data),  32'(0));
        check_state("reset", 5'd0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].pv)
                exp_q.push_back(vecs[i].pd);
            apply(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tos,
                        vecs[i].ovf, vecs[i].udf);
        end

        // Fill to full, overflow, frozen pop, recovery.
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'(i));
            check("fill.count", 32'(count), 32'(i + 1));
        end
        check_state("full", 5'd16, 8'h0F, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'hAA);
        check_state("ovf", 5'd16, 8'h0F, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00);                 // ignored in error state
        check_state("ovf_pop", 5'd16, 8'h0F, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("ovf_clr", 5'd16, 8'h0F, 1'b0, 1'b0);
        exp_q.push_back(8'h0F);
        apply(1'b0, 1'b1, 1'b0, 8'h00);
        check_state("post_clr_pop", 5'd15, 8'h0E, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h3C);
        check_state("refill", 5'd16, 8'h3C, 1'b0, 1'b0);
        exp_q.push_back(8'h3C);
        apply(1'b1, 1'b1, 1'b0, 8'h5A);                 // replace while full
        check_state("swap_full", 5'd16, 8'h5A, 1'b0, 1'b0);

        // Reset asserted in the middle of a cycle with a pop result showing.
        rst = 1'b1;
        #4;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            apply(1'b1, 1'b0, 1'b0, 8'h44);
        check_state("pre_rst", 5'd4, 8'h44, 1'b0, 1'b0);
        exp_q.push_back(8'h44);
        apply(1'b0, 1'b1, 1'b0, 8'h00);
        push = 1'b1;
        push_data = 8'h55;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.pop_valid", 32'(pop_valid), 32'(0));
        check_state("rst_mid", 5'd0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_state("rst_held", 5'd0, 8'h00, 1'b0, 1'b0);
        rst  = 1'b0;
        push = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        check_state("post_rst", 5'd0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
